// File: rtl/period_meter.sv
// period_meter: measures the rising-to-rising period and the high time of a
// slow, asynchronous square wave, counted in clk cycles. The first rising edge
// after arming only aligns phase. Later rising edges publish period/high_time
// together with a one-cycle valid pulse. A sticky timeout flag reports a
// missing edge.
module period_meter #(
  parameter int WIDTH   = 23,
  parameter int TIMEOUT = 8000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] TMO = WIDTH'(TIMEOUT);

  logic             s1, s2, s3;
  logic             rise, fall;
  state_t           state, state_d;
  logic [WIDTH-1:0] cnt, cnt_d, cnt_inc;
  logic [WIDTH-1:0] hi_reg, hi_d;
  logic [WIDTH-1:0] period_d, high_d;
  logic             valid_d, timeout_d;
  logic             at_limit;

  assign rise      = s2 & ~s3;
  assign fall      = ~s2 & s3;
  assign at_limit  = (cnt == TMO);
  // Saturating increment keeps the counter from ever passing TIMEOUT. This
  // matters when a falling edge lands on the limit cycle: the edge is still
  // honoured, and the limit is then reached again in LOW.
  assign cnt_inc   = at_limit ? cnt : cnt + 1'b1;
  assign state_dbg = state;

  // Two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Counter, captured high time and registered measurement outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      hi_reg    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      cnt       <= cnt_d;
      hi_reg    <= hi_d;
      period    <= period_d;
      high_time <= high_d;
      valid     <= valid_d;
      timeout   <= timeout_d;
    end
  end

  // Next-state and datapath decisions. An edge wins over the timeout check,
  // and a low enable wins over everything except reset.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt_inc;
    hi_d      = hi_reg;
    period_d  = period;
    high_d    = high_time;
    valid_d   = 1'b0;
    timeout_d = timeout;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_d = ARM;
          cnt_d   = '0;
        end
        ARM: begin
          if (rise) begin
            state_d = HIGH;
            cnt_d   = WIDTH'(1);
          end else if (at_limit) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
          end
        end
        HIGH: begin
          if (fall) begin
            state_d = LOW;
            hi_d    = cnt;
          end else if (at_limit) begin
            timeout_d = 1'b1;
            state_d   = ARM;
            cnt_d     = '0;
          end
        end
        LOW: begin
          if (rise) begin
            state_d   = HIGH;
            period_d  = cnt;
            high_d    = hi_reg;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = WIDTH'(1);
          end else if (at_limit) begin
            timeout_d = 1'b1;
            state_d   = ARM;
            cnt_d     = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with WIDTH=8, TIMEOUT=100.
module tb_period_meter;

  localparam int W   = 8;
  localparam int TMO = 100;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         sig_in = 1'b0;
  logic [W-1:0] period, high_time;
  logic         valid, timeout;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  period_meter #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_e;
  int n_checks = 0;
  int n_err    = 0;
  int vcnt     = 0;
  int dbl      = 0;
  bit prev_v   = 1'b0;
  bit rand_mode = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Monitor: every valid pulse is matched against the expected queue, or
  // against the tolerance window while the random-phase wave runs.
  always @(negedge clk) begin
    if (valid) begin
      vcnt++;
      if (prev_v) dbl++;
      if (rand_mode) begin
        chk("rand_period_in_39_41", 32'((period >= 8'd39) && (period <= 8'd41)), 32'd1);
        chk("rand_high_in_19_21", 32'((high_time >= 8'd19) && (high_time <= 8'd21)), 32'd1);
      end else if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("valid_period", 32'(period), 32'(mon_e[2*W-1:W]));
        chk("valid_high_time", 32'(high_time), 32'(mon_e[W-1:0]));
      end
    end
    prev_v = valid;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    sig_in = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    exp_q.delete();
    vcnt = 0;
  endtask

  task automatic push_exp(input int p, input int h);
    exp_q.push_back({W'(p), W'(h)});
  endtask

  task automatic drive_wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      repeat (hi) step();
      sig_in = 1'b0;
      repeat (lo) step();
    end
  endtask

  // Hard stop in case something never completes
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  int v0;
  int r;

  initial begin
    // Reset state
    do_reset();
    chk("reset_period", 32'(period), 32'd0);
    chk("reset_high_time", 32'(high_time), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    chk("reset_state_idle", 32'(state_dbg), 32'd0);

    // 20 high / 30 low: first rise aligns only, later rises report 50/20
    enable = 1'b1;
    repeat (5) step();
    chk("t1_state_arm", 32'(state_dbg), 32'd1);
    drive_wave(20, 30, 1);
    chk("t1_first_rise_no_valid", 32'(vcnt), 32'd0);
    push_exp(50, 20); push_exp(50, 20); push_exp(50, 20);
    drive_wave(20, 30, 3);
    chk("t1_pending", 32'(exp_q.size()), 32'd0);
    push_exp(50, 20);
    sig_in = 1'b1;
    step(); step();
    chk("t1_valid_not_early", 32'(valid), 32'd0);
    step();
    chk("t1_valid_pulse", 32'(valid), 32'd1);
    chk("t1_period_50", 32'(period), 32'd50);
    chk("t1_high_20", 32'(high_time), 32'd20);
    step();
    chk("t1_valid_one_cycle", 32'(valid), 32'd0);
    chk("t1_no_timeout", 32'(timeout), 32'd0);

    // Missing edge: timeout 101 cycles after entering ARM, cleared by 40/40
    do_reset();
    enable = 1'b1;
    repeat (101) step();
    chk("t2_timeout_not_early", 32'(timeout), 32'd0);
    step();
    chk("t2_timeout_set", 32'(timeout), 32'd1);
    chk("t2_state_arm", 32'(state_dbg), 32'd1);
    drive_wave(40, 40, 1);
    chk("t2_timeout_sticky", 32'(timeout), 32'd1);
    push_exp(80, 40);
    drive_wave(40, 40, 1);
    chk("t2_pending", 32'(exp_q.size()), 32'd0);
    chk("t2_timeout_cleared", 32'(timeout), 32'd0);
    chk("t2_period_80", 32'(period), 32'd80);
    chk("t2_high_40", 32'(high_time), 32'd40);

    // Enable dropped mid-HIGH for 5 cycles
    do_reset();
    enable = 1'b1;
    step();
    push_exp(50, 20);
    drive_wave(20, 30, 2);
    push_exp(50, 20);
    sig_in = 1'b1;
    repeat (10) step();
    chk("t3_pending_pre_drop", 32'(exp_q.size()), 32'd0);
    v0 = vcnt;
    enable = 1'b0;
    repeat (5) step();
    chk("t3_drop_idle", 32'(state_dbg), 32'd0);
    chk("t3_drop_period_held", 32'(period), 32'd50);
    chk("t3_drop_high_held", 32'(high_time), 32'd20);
    chk("t3_drop_no_valid", 32'(vcnt), 32'(v0));
    enable = 1'b1;
    repeat (5) step();
    sig_in = 1'b0;
    repeat (30) step();
    sig_in = 1'b1;
    repeat (20) step();
    chk("t3_post_enable_first_no_valid", 32'(vcnt), 32'(v0));
    sig_in = 1'b0;
    repeat (30) step();
    push_exp(50, 20);
    sig_in = 1'b1;
    repeat (5) step();
    chk("t3_post_enable_second_valid", 32'(vcnt), 32'(v0 + 1));
    chk("t3_pending", 32'(exp_q.size()), 32'd0);

    // Reset during LOW of a 10/10 wave
    do_reset();
    enable = 1'b1;
    step();
    push_exp(20, 10); push_exp(20, 10);
    drive_wave(10, 10, 3);
    chk("t4_pending_pre_reset", 32'(exp_q.size()), 32'd0);
    chk("t4_state_low", 32'(state_dbg), 32'd3);
    reset = 1'b1;
    step();
    chk("t4_reset_period", 32'(period), 32'd0);
    chk("t4_reset_high", 32'(high_time), 32'd0);
    chk("t4_reset_valid", 32'(valid), 32'd0);
    chk("t4_reset_timeout", 32'(timeout), 32'd0);
    chk("t4_reset_idle", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    step();
    chk("t4_resume_arm", 32'(state_dbg), 32'd1);
    v0 = vcnt;
    drive_wave(10, 10, 1);
    chk("t4_first_rise_no_valid", 32'(vcnt), 32'(v0));
    push_exp(20, 10);
    drive_wave(10, 10, 1);
    chk("t4_pending", 32'(exp_q.size()), 32'd0);
    chk("t4_period_20", 32'(period), 32'd20);

    // Rise exactly on the limit cycle (period 100): edge wins
    do_reset();
    enable = 1'b1;
    step();
    push_exp(100, 50); push_exp(100, 50);
    drive_wave(50, 50, 2);
    sig_in = 1'b1;
    repeat (5) step();
    chk("t5_pending", 32'(exp_q.size()), 32'd0);
    chk("t5_period_100", 32'(period), 32'd100);
    chk("t5_timeout_clear", 32'(timeout), 32'd0);

    // Period 101: limit reached one cycle before the rise, so timeout
    do_reset();
    enable = 1'b1;
    step();
    drive_wave(50, 51, 1);
    sig_in = 1'b1;
    repeat (5) step();
    chk("t5b_timeout_set", 32'(timeout), 32'd1);
    chk("t5b_no_valid", 32'(vcnt), 32'd0);
    chk("t5b_state_high", 32'(state_dbg), 32'd2);

    // Random phase: 400 ns frames, 200 ns high, rise jittered 1..8 ns
    do_reset();
    enable = 1'b1;
    step();
    rand_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      r = $urandom_range(1, 8);
      #(r);
      sig_in = 1'b1;
      #200;
      sig_in = 1'b0;
      #(200 - r);
    end
    repeat (5) step();
    rand_mode = 1'b0;
    chk("t6_valid_count", 32'(vcnt), 32'd9);

    chk("no_back_to_back_valid", 32'(dbl), 32'd0);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter WIDTH, default 23, width of counter and measurement outputs.
REQ-002 Parameter TIMEOUT, default 8000000, cycle count after which a missing edge is declared; SHALL be < 2^WIDTH.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  measurement enable; low holds block idle.
REQ-006 sig_in  input  1  slow square wave, asynchronous to clk (e.g. a divided tick clock).
REQ-007 period  output  WIDTH  last measured rising-to-rising period, in clk cycles.
REQ-008 high_time  output  WIDTH  last measured rising-to-falling high time, in clk cycles.
REQ-009 valid  output  1  one-cycle pulse marking new period/high_time.
REQ-010 timeout  output  1  sticky flag: no edge within TIMEOUT cycles.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchronizer (s1, s2) plus one history flop (s3); rise = s2 & ~s3, fall = ~s2 & s3.
REQ-012 FSM states SHALL be IDLE, ARM, HIGH, LOW.
REQ-013 IDLE: counter held 0; enable=1 -> ARM next cycle.
REQ-014 ARM: counter increments each cycle; rise -> HIGH, counter <= 1, no valid (first edge only aligns phase); fall ignored.
REQ-015 HIGH: counter increments; fall -> LOW, internal hi_reg <= counter, counter increments.
REQ-016 LOW: counter increments; rise -> HIGH, period <= counter, high_time <= hi_reg, valid <= 1, timeout <= 0, counter <= 1.
REQ-017 For a synchronized wave with period P and high time H cycles, reported values SHALL equal exactly P and H.
REQ-018 period, high_time, valid SHALL be registered; new values and valid appear in the cycle after the rise cycle.
REQ-019 valid SHALL be high for exactly one cycle per completed period; period/high_time SHALL hold until the next valid.
REQ-020 Timeout: in ARM, HIGH or LOW, counter == TIMEOUT with no edge that cycle -> timeout <= 1, state <= ARM, counter <= 0.
REQ-021 Edge and timeout condition in the same cycle: edge SHALL take priority; timeout not set.
REQ-022 Counter SHALL never exceed TIMEOUT; no wrap-around.
REQ-023 enable low in any state -> IDLE next cycle, counter 0, valid 0, period/high_time/timeout held.
REQ-024 enable deassert in the same cycle as a rise: enable wins; no valid.
REQ-025 Re-enable SHALL restart at ARM; first post-enable edge produces no valid.

Reset
REQ-026 reset SHALL have priority over enable and all edges.
REQ-027 reset -> state IDLE, counter 0, s1/s2/s3 0, period 0, high_time 0, valid 0, timeout 0.
REQ-028 reset mid-measurement SHALL discard partial counts; no valid for the interrupted period.

Verification (bench TIMEOUT=100, WIDTH=8)
REQ-029 reset, enable=1, sig_in square wave 20 high/30 low -> first rise gives no valid; each later rise: valid 1 cycle, period=50, high_time=20.
REQ-030 sig_in held 0 after enable -> timeout=1 exactly 101 cycles after entering ARM; next full 40/40 period clears timeout with period=80, high_time=40.
REQ-031 enable dropped mid-HIGH for 5 cycles, then raised -> no valid during drop, outputs hold prior values, first post-enable rise no valid, next rise valid.
REQ-032 reset asserted during LOW of a 10/10 wave -> all outputs 0 next cycle; measurement resumes from ARM after release.
REQ-033 rise arriving exactly when counter == TIMEOUT (period 100) -> valid with period=100, timeout stays 0.
REQ-034 sig_in toggling with random async phase relative to clk -> reported period within ±1 of nominal, valid never two consecutive cycles.
